sa_5x5_alloc: RTL

- Switch allocator for the 5-port mesh router.
- Takes the per-input-port routing results (data + 4-bit direction from the route-compute stage) for ports N, E, W, S, L.
- Grants output ports to input ports with per-output round-robin and wormhole locking (head→tail), under downstream backpressure.
- Drives crossbar selects and input-FIFO pop strobes; sits between route compute and the crossbar.

---
 rtl/sa_5x5_alloc_pkg.sv | 58 +++++
 rtl/sa_5x5_alloc_if.sv | 30 +++
 rtl/sa_5x5_alloc_out_arb.sv | 101 ++++++++++
 rtl/sa_5x5_alloc.sv | 74 +++++++
 4 files changed

// File: rtl/sa_5x5_alloc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sa_pkg
// Brief    : Shared constants, types and helpers for the 5x5 switch allocator.
// Revision : 1.0 - initial release
// ============================================================================
package sa_pkg;

    localparam int NPORT = 5;
    localparam int DIRW  = 4;
    localparam int SELW  = 3;

    localparam logic [DIRW-1:0] DIR_N = 4'd0;
    localparam logic [DIRW-1:0] DIR_E = 4'd1;
    localparam logic [DIRW-1:0] DIR_W = 4'd2;
    localparam logic [DIRW-1:0] DIR_S = 4'd3;
    localparam logic [DIRW-1:0] DIR_L = 4'd4;

    localparam logic [SELW-1:0] SEL_NONE = 3'd7;

    typedef enum logic [1:0] {
        FT_HEAD   = 2'd0,
        FT_BODY   = 2'd1,
        FT_TAIL   = 2'd2,
        FT_SINGLE = 2'd3
    } ftype_t;

    typedef enum logic [0:0] {
        ST_FREE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] p);
        return (p >= SELW'(NPORT - 1)) ? '0 : p + 1'b1;
    endfunction

    // Returns {found, index} of the first set bit at or after ptr, wrapping mod NPORT.
    function automatic logic [SELW:0] rr_pick(input logic [NPORT-1:0] req,
                                              input logic [SELW-1:0]  ptr);
        logic [SELW:0]   res;
        logic [SELW:0]   sum;
        logic [SELW-1:0] idx;
        res = {1'b0, SEL_NONE};
        for (int k = NPORT - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + 4'(k);
            if (sum >= 4'(NPORT)) begin
                sum = sum - 4'(NPORT);
            end
            idx = sum[SELW-1:0];
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sa_5x5_alloc_if.sv
`default_nettype none
// ============================================================================
// Module   : sa_5x5_alloc_if
// Brief    : Route-compute / crossbar facing bundle of the switch allocator.
// Revision : 1.0 - initial release
// ============================================================================
interface sa_5x5_alloc_if;
    import sa_pkg::*;

    logic [NPORT-1:0]      in_valid;
    logic [NPORT*DIRW-1:0] in_dir;
    logic [2*NPORT-1:0]    in_ftype;
    logic [NPORT-1:0]      out_ready;
    logic [NPORT-1:0]      in_grant;
    logic [NPORT-1:0]      out_valid;
    logic [NPORT*SELW-1:0] xbar_sel;
    logic [NPORT-1:0]      out_locked;
    logic                  err_dir;

    modport master (
        output in_valid, in_dir, in_ftype, out_ready,
        input  in_grant, out_valid, xbar_sel, out_locked, err_dir
    );

    modport slave (
        input  in_valid, in_dir, in_ftype, out_ready,
        output in_grant, out_valid, xbar_sel, out_locked, err_dir
    );
endinterface
`default_nettype wire

// File: rtl/sa_5x5_alloc_out_arb.sv
`default_nettype none
// ============================================================================
// Module   : sa_out_arb
// Brief    : Per-output round-robin arbiter with wormhole (head-to-tail) lock.
// Revision : 1.0 - initial release
// ============================================================================
module sa_out_arb
    import sa_pkg::*;
(
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic [NPORT-1:0]     i_req,
    input  wire logic [2*NPORT-1:0]   i_ftype,
    input  wire logic                 i_ready,
    output logic      [NPORT-1:0]     o_grant,
    output logic      [SELW-1:0]      o_sel,
    output logic                      o_lock,
    output logic                      o_err
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [SELW-1:0]  r_owner;
    logic [SELW-1:0]  w_owner_nxt;
    logic [SELW-1:0]  r_rr;
    logic [SELW-1:0]  w_rr_nxt;
    ftype_t           w_ft [NPORT];
    logic [NPORT-1:0] w_open;
    logic [NPORT-1:0] w_cont;
    logic [SELW:0]    w_pick;
    logic [SELW-1:0]  w_win;

    // open = packet starters (HEAD/SINGLE), cont = packet continuations (BODY/TAIL)
    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            w_ft[i]   = ftype_t'(i_ftype[2*i +: 2]);
            w_open[i] = i_req[i] && ((w_ft[i] == FT_HEAD) || (w_ft[i] == FT_SINGLE));
            w_cont[i] = i_req[i] && ((w_ft[i] == FT_BODY) || (w_ft[i] == FT_TAIL));
        end
    end

    assign w_pick = rr_pick(w_open, r_rr);
    assign w_win  = w_pick[SELW-1:0];
    assign o_lock = (r_state == ST_LOCKED);

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr;
        o_grant     = '0;
        o_sel       = SEL_NONE;
        o_err       = 1'b0;
        case (r_state)
            ST_FREE: begin
                o_err = |w_cont;
                if (i_ready && w_pick[SELW]) begin
                    o_grant[w_win] = 1'b1;
                    o_sel          = w_win;
                    w_rr_nxt       = wrap_inc(w_win);
                    if (w_ft[w_win] == FT_HEAD) begin
                        w_state_nxt = ST_LOCKED;
                        w_owner_nxt = w_win;
                    end
                end
            end
            ST_LOCKED: begin
                // Non-owners simply wait; only the owner can misbehave here.
                if (i_req[r_owner]) begin
                    if (w_cont[r_owner]) begin
                        if (i_ready) begin
                            o_grant[r_owner] = 1'b1;
                            o_sel            = r_owner;
                            if (w_ft[r_owner] == FT_TAIL) begin
                                w_state_nxt = ST_FREE;
                            end
                        end
                    end else begin
                        o_err = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_FREE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FREE;
            r_owner <= '0;
            r_rr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_rr    <= w_rr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sa_5x5_alloc.sv
`default_nettype none
// ============================================================================
// Module   : sa_5x5_alloc
// Brief    : 5-port mesh router switch allocator (decode, per-output arbiters).
// Revision : 1.0 - initial release
// ============================================================================
module sa_5x5_alloc
    import sa_pkg::*;
(
    input  wire logic      sa_clk,
    input  wire logic      rst,
    sa_5x5_alloc_if.slave  bus
);

    logic [NPORT-1:0]      w_req   [NPORT];
    logic [NPORT-1:0]      w_grant [NPORT];
    logic [SELW-1:0]       w_sel   [NPORT];
    logic [NPORT-1:0]      w_bad_dir;
    logic [NPORT-1:0]      w_lock;
    logic [NPORT-1:0]      w_arb_err;
    logic [NPORT-1:0]      w_in_grant;
    logic [NPORT-1:0]      w_out_valid;
    logic [NPORT*SELW-1:0] w_xbar_sel;

    // w_req[o][i]: input i is asking for output o this cycle
    always_comb begin
        w_bad_dir = '0;
        for (int o = 0; o < NPORT; o++) begin
            w_req[o] = '0;
        end
        for (int i = 0; i < NPORT; i++) begin
            w_bad_dir[i] = bus.in_valid[i] && (bus.in_dir[DIRW*i +: DIRW] >= DIRW'(NPORT));
            for (int o = 0; o < NPORT; o++) begin
                w_req[o][i] = bus.in_valid[i] && (bus.in_dir[DIRW*i +: DIRW] == DIRW'(o));
            end
        end
    end

    generate
        for (genvar o = 0; o < NPORT; o++) begin : g_arb
            sa_out_arb u_arb (
                .clk     (sa_clk),
                .rst     (rst),
                .i_req   (w_req[o]),
                .i_ftype (bus.in_ftype),
                .i_ready (bus.out_ready[o]),
                .o_grant (w_grant[o]),
                .o_sel   (w_sel[o]),
                .o_lock  (w_lock[o]),
                .o_err   (w_arb_err[o])
            );
        end
    endgenerate

    always_comb begin
        w_in_grant  = '0;
        w_out_valid = '0;
        w_xbar_sel  = '1;
        for (int o = 0; o < NPORT; o++) begin
            w_in_grant                  = w_in_grant | w_grant[o];
            w_out_valid[o]              = |w_grant[o];
            w_xbar_sel[SELW*o +: SELW]  = w_sel[o];
        end
    end

    // Reset is asynchronous, so outputs are masked combinationally while it is held.
    assign bus.in_grant   = rst ? '0 : w_in_grant;
    assign bus.out_valid  = rst ? '0 : w_out_valid;
    assign bus.xbar_sel   = rst ? '1 : w_xbar_sel;
    assign bus.out_locked = rst ? '0 : w_lock;
    assign bus.err_dir    = rst ? 1'b0 : ((|w_bad_dir) || (|w_arb_err));

endmodule
`default_nettype wire
